// File: rtl/pool_window_gen_pkg.sv
// Shared types and constants for the 2x2 pooling window generator.
package pool_window_gen_pkg;

    typedef enum logic [1:0] {
        ROW_TOP  = 2'd0,
        ROW_BOT  = 2'd1,
        ROW_SKIP = 2'd2
    } row_state_e;

    // Element positions inside one fmap slice of a window
    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BL = 2;
    localparam int BR = 3;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two combinational read addresses.
module pool_line_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Contents are deliberately not reset; a top row is always rewritten before it is read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows for a pooling stage.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int NFMAPS   = 32,
    parameter int KER_SIZE = 2,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   in_valid,
    input  logic                                   in_sof,
    input  logic [NBITS*NFMAPS-1:0]                in_act,
    output logic                                   valid,
    output logic [NBITS*KER_SIZE*KER_SIZE*NFMAPS-1:0] window_act,
    output logic                                   frame_done
);

    localparam int PIX_W = NBITS * NFMAPS;
    localparam int WIN_W = NBITS * KER_SIZE * KER_SIZE * NFMAPS;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] PRE_SKIP_ROW = RW'(IMG_H - 2);
    localparam bit            ODD_H        = (IMG_H % 2) == 1;

    generate
        if (KER_SIZE != 2) begin : g_bad_ker
            $error("pool_window_gen supports only KER_SIZE == 2");
        end
        if (IMG_W < 2 || IMG_H < 2) begin : g_bad_img
            $error("pool_window_gen needs IMG_W >= 2 and IMG_H >= 2");
        end
    endgenerate

    row_state_e       state_r, state_nxt_s, cur_state_s;
    logic [CW-1:0]    col_r, col_nxt_s, cur_col_s;
    logic [RW-1:0]    row_r, row_nxt_s, cur_row_s;
    logic             end_row_s, end_frame_s;
    logic             lb_we_s, hold_we_s, win_fire_s;
    logic [PIX_W-1:0] lb_rd0_s, lb_rd1_s, hold_r;
    logic [WIN_W-1:0] window_s, window_r;
    logic             valid_r, frame_done_r;

    // A start-of-frame pixel overrides the tracked position and row phase
    assign cur_col_s   = in_sof ? {CW{1'b0}} : col_r;
    assign cur_row_s   = in_sof ? {RW{1'b0}} : row_r;
    assign cur_state_s = in_sof ? ROW_TOP : state_r;
    assign end_row_s   = (cur_col_s == LAST_COL);
    assign end_frame_s = end_row_s && (cur_row_s == LAST_ROW);

    assign lb_we_s    = in_valid && (cur_state_s == ROW_TOP);
    assign hold_we_s  = in_valid && (cur_state_s == ROW_BOT) && !cur_col_s[0];
    assign win_fire_s = in_valid && (cur_state_s == ROW_BOT) && cur_col_s[0];

    pool_line_buffer #(
        .WIDTH (PIX_W),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk    (clk),
        .we     (lb_we_s),
        .waddr  (cur_col_s),
        .wdata  (in_act),
        .raddr0 (cur_col_s - CW'(1)),
        .raddr1 (cur_col_s),
        .rdata0 (lb_rd0_s),
        .rdata1 (lb_rd1_s)
    );

    // Row-phase next state; the odd last row of a frame is skipped
    always_comb begin
        state_nxt_s = state_r;
        if (in_valid) begin
            case (cur_state_s)
                ROW_TOP: begin
                    if (end_row_s) state_nxt_s = ROW_BOT;
                    else           state_nxt_s = ROW_TOP;
                end
                ROW_BOT: begin
                    if (end_frame_s)                               state_nxt_s = ROW_TOP;
                    else if (end_row_s && ODD_H && (cur_row_s == PRE_SKIP_ROW)) state_nxt_s = ROW_SKIP;
                    else if (end_row_s)                            state_nxt_s = ROW_TOP;
                    else                                           state_nxt_s = ROW_BOT;
                end
                ROW_SKIP: begin
                    if (end_frame_s) state_nxt_s = ROW_TOP;
                    else             state_nxt_s = ROW_SKIP;
                end
                default: state_nxt_s = ROW_TOP;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Raster position of the next pixel
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (!in_valid) begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end else if (end_frame_s) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = {RW{1'b0}};
        end else if (end_row_s) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = cur_row_s + RW'(1);
        end else begin
            col_nxt_s = cur_col_s + CW'(1);
            row_nxt_s = cur_row_s;
        end
    end

    // Window assembly: top pair from the line buffer, bottom pair from held and current pixel
    always_comb begin
        window_s = {WIN_W{1'b0}};
        for (int i = 0; i < NFMAPS; i++) begin
            window_s[i*4*NBITS + TL*NBITS +: NBITS] = lb_rd0_s[i*NBITS +: NBITS];
            window_s[i*4*NBITS + TR*NBITS +: NBITS] = lb_rd1_s[i*NBITS +: NBITS];
            window_s[i*4*NBITS + BL*NBITS +: NBITS] = hold_r[i*NBITS +: NBITS];
            window_s[i*4*NBITS + BR*NBITS +: NBITS] = in_act[i*NBITS +: NBITS];
        end
    end

    // State, position, held pixel and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ROW_TOP;
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            hold_r       <= {PIX_W{1'b0}};
            window_r     <= {WIN_W{1'b0}};
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            valid_r      <= win_fire_s;
            frame_done_r <= in_valid && end_frame_s;
            if (hold_we_s) begin
                hold_r <= in_act;
            end
            if (win_fire_s) begin
                window_r <= window_s;
            end
        end
    end

    assign valid      = valid_r;
    assign window_act = window_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench: 4x4 two-fmap instance and 5x5 single-fmap instance.
module tb_pool_window_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_valid, a_sof, a_vout, a_fd;
    logic [15:0] a_act;
    logic [63:0] a_win;
    logic        b_valid, b_sof, b_vout, b_fd;
    logic [7:0]  b_act;
    logic [31:0] b_win;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pool_window_gen #(.NBITS(8), .NFMAPS(2), .KER_SIZE(2), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(a_valid), .in_sof(a_sof), .in_act(a_act),
        .valid(a_vout), .window_act(a_win), .frame_done(a_fd)
    );

    pool_window_gen #(.NBITS(8), .NFMAPS(1), .KER_SIZE(2), .IMG_W(5), .IMG_H(5)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(b_valid), .in_sof(b_sof), .in_act(b_act),
        .valid(b_vout), .window_act(b_win), .frame_done(b_fd)
    );

    // fmap1 carries fmap0 + 0x80
    task automatic drive_a(input logic v, input logic s, input logic [7:0] px);
        a_valid = v;
        a_sof   = s;
        a_act   = {px + 8'h80, px};
        @(negedge clk);
    endtask

    task automatic drive_b(input logic v, input logic s, input logic [7:0] px);
        b_valid = v;
        b_sof   = s;
        b_act   = px;
        @(negedge clk);
    endtask

    function automatic logic [63:0] exp_win(input logic [7:0] tl, tr, bl, br);
        return {br + 8'h80, bl + 8'h80, tr + 8'h80, tl + 8'h80, br, bl, tr, tl};
    endfunction

    function automatic logic [63:0] exp_4x4(input logic [7:0] base, input int w);
        case (w)
            0:       return exp_win(base + 8'd1,  base + 8'd2,  base + 8'd5,  base + 8'd6);
            1:       return exp_win(base + 8'd3,  base + 8'd4,  base + 8'd7,  base + 8'd8);
            2:       return exp_win(base + 8'd9,  base + 8'd10, base + 8'd13, base + 8'd14);
            default: return exp_win(base + 8'd11, base + 8'd12, base + 8'd15, base + 8'd16);
        endcase
    endfunction

    task automatic stream_4x4(input string name, input logic [7:0] base, input logic gapped,
                              input logic sof_first);
        int   w;
        logic exp_v;
        w = 0;
        for (int p = 1; p <= 16; p++) begin
            drive_a(1'b1, sof_first && (p == 1), base + 8'(p));
            exp_v = (p == 6) || (p == 8) || (p == 14) || (p == 16);
            n_vec++;
            if (a_vout !== exp_v) begin
                n_err++;
                $display("FAIL %s valid after pixel %0d: got %b want %b", name, p, a_vout, exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (a_win !== exp_4x4(base, w)) begin
                    n_err++;
                    $display("FAIL %s window %0d: got %h want %h", name, w, a_win, exp_4x4(base, w));
                end
                w++;
            end
            n_vec++;
            if (a_fd !== (p == 16)) begin
                n_err++;
                $display("FAIL %s frame_done after pixel %0d: got %b want %b", name, p, a_fd, (p == 16));
            end
            if (gapped) begin
                drive_a(1'b0, 1'b0, 8'hEE);
                n_vec++;
                if (a_vout !== 1'b0 || a_fd !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s idle after pixel %0d: got valid=%b fd=%b want 0 0", name, p, a_vout, a_fd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive_a(1'b0, 1'b0, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (a_vout !== 1'b0 || a_win !== 64'h0 || a_fd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: got valid=%b win=%h fd=%b want 0 0 0", a_vout, a_win, a_fd);
        end
        n_vec++;
        if (b_vout !== 1'b0 || b_win !== 32'h0 || b_fd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: got valid=%b win=%h fd=%b want 0 0 0", b_vout, b_win, b_fd);
        end
        rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        stream_4x4("b2b", 8'd0, 1'b0, 1'b1);
        drive_a(1'b0, 1'b0, 8'h55);
        drive_a(1'b0, 1'b0, 8'h66);
        n_vec++;
        if (a_vout !== 1'b0 || a_win !== exp_4x4(8'd0, 3)) begin
            n_err++;
            $display("FAIL hold: got valid=%b win=%h want 0 %h", a_vout, a_win, exp_4x4(8'd0, 3));
        end
    endtask

    task automatic test_gapped();
        stream_4x4("gapped", 8'd0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midframe();
        for (int p = 1; p <= 7; p++) begin
            drive_a(1'b1, p == 1, 8'(p + 40));
        end
        rstn = 1'b0;
        drive_a(1'b0, 1'b0, 8'h00);
        rstn = 1'b1;
        n_vec++;
        if (a_vout !== 1'b0 || a_win !== 64'h0) begin
            n_err++;
            $display("FAIL midreset clear: got valid=%b win=%h want 0 0", a_vout, a_win);
        end
        stream_4x4("midreset", 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_sof();
        drive_a(1'b1, 1'b1, 8'd1);
        drive_a(1'b1, 1'b0, 8'd2);
        stream_4x4("sof", 8'd100, 1'b0, 1'b1);
    endtask

    task automatic test_odd_5x5();
        logic        exp_v;
        logic [31:0] exp_w;
        for (int p = 1; p <= 25; p++) begin
            drive_b(1'b1, p == 1, 8'(p));
            exp_v = (p == 7) || (p == 9) || (p == 17) || (p == 19);
            case (p)
                7:       exp_w = {8'd7, 8'd6, 8'd2, 8'd1};
                9:       exp_w = {8'd9, 8'd8, 8'd4, 8'd3};
                17:      exp_w = {8'd17, 8'd16, 8'd12, 8'd11};
                default: exp_w = {8'd19, 8'd18, 8'd14, 8'd13};
            endcase
            n_vec++;
            if (b_vout !== exp_v) begin
                n_err++;
                $display("FAIL odd valid after pixel %0d: got %b want %b", p, b_vout, exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (b_win !== exp_w) begin
                    n_err++;
                    $display("FAIL odd window after pixel %0d: got %h want %h", p, b_win, exp_w);
                end
            end
            n_vec++;
            if (b_fd !== (p == 25)) begin
                n_err++;
                $display("FAIL odd frame_done after pixel %0d: got %b want %b", p, b_fd, (p == 25));
            end
        end
        b_valid = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        a_valid = 1'b0;
        a_sof   = 1'b0;
        a_act   = 16'h0;
        b_valid = 1'b0;
        b_sof   = 1'b0;
        b_act   = 8'h0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_reset_midframe();
        test_sof();
        test_odd_5x5();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 Parameter NBITS, 32, bits per activation element.
REQ-002 Parameter NFMAPS, 32, feature maps carried in parallel per pixel.
REQ-003 Parameter KER_SIZE, 2, pooling window edge; only 2 is supported, and any other value SHALL fail elaboration.
REQ-004 Parameter IMG_W, 8, input row width in pixels; minimum 2.
REQ-005 Parameter IMG_H, 8, input rows per frame; minimum 2.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rstn  input  1  synchronous, active-low reset.
REQ-008 in_valid  input  1  in_act carries one pixel this cycle.
REQ-009 in_sof  input  1  qualified by in_valid; this pixel is frame position (0,0).
REQ-010 in_act  input  NBITS*NFMAPS  one pixel, all fmaps; fmap i at [(i+1)*NBITS-1 : i*NBITS].
REQ-011 valid  output  1  window_act holds a complete 2x2 window this cycle; drives the pooling stage valid.
REQ-012 window_act  output  NBITS*KER_SIZE*KER_SIZE*NFMAPS  window; fmap i slice at [(i+1)*4*NBITS-1 : i*4*NBITS]; inside a slice element 0=(r,c), 1=(r,c+1), 2=(r+1,c), 3=(r+1,c+1), element k at [(k+1)*NBITS-1 : k*NBITS].
REQ-013 frame_done  output  1  one-cycle pulse; last pixel of frame accepted.

Function
REQ-014 Input is raster order, row-major; pixels are accepted every cycle in_valid=1 (no backpressure); in_valid=0 SHALL hold all state.
REQ-015 Column counter col 0..IMG_W-1 and row counter row 0..IMG_H-1 SHALL advance per accepted pixel; col wraps to 0 and increments row; after (IMG_W-1, IMG_H-1) both wrap to 0.
REQ-016 in_valid=1 with in_sof=1 SHALL treat the current pixel as (0,0), discarding any partial frame and partial window.
REQ-017 FSM states: ROW_TOP (even row, write pixel to line buffer at col), ROW_BOT (odd row, emit windows), ROW_SKIP (last row when IMG_H odd, pixels discarded).
REQ-018 Transitions: ROW_TOP->ROW_BOT at end of row; ROW_BOT->ROW_TOP at end of row unless the next row is IMG_H-1 with IMG_H odd, then ROW_SKIP; ROW_SKIP->ROW_TOP at end of frame; ROW_BOT->ROW_TOP at end of frame; in_sof forces ROW_TOP.
REQ-019 Line buffer: IMG_W entries of NBITS*NFMAPS, written only in ROW_TOP.
REQ-020 In ROW_BOT at even col, the pixel SHALL be held in a one-pixel register; at odd col, a window is formed from linebuf[col-1], linebuf[col], held pixel, current pixel.
REQ-021 valid and window_act SHALL be registered: valid=1 exactly one cycle after the accept cycle of pixel (r+1,c+1), otherwise 0.
REQ-022 IMG_W odd: last column of each row SHALL be stored/discarded but never form a window; windows per frame = floor(IMG_W/2)*floor(IMG_H/2).
REQ-023 window_act SHALL hold its last value while valid=0.
REQ-024 frame_done SHALL assert one cycle after the accept of pixel (IMG_W-1, IMG_H-1), coincident with valid for that window when one is formed.
REQ-025 Data is passed bit-exact; no arithmetic on activations.

Reset
REQ-026 With rstn=0 at a clock edge: col=0, row=0, state ROW_TOP, valid=0, window_act=0, frame_done=0, held pixel=0.
REQ-027 Line buffer contents are not reset; no window is formed from pre-reset top-row data.
REQ-028 Reset mid-frame SHALL abandon the frame; next accepted pixel is (0,0).

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the window element index constants (TL=0, TR=1, BL=2, BR=3).
REQ-030 One sub-module, pool_line_buffer (single-write, dual-read-address register array), SHALL implement the line buffer.

Verification
REQ-031 NBITS=8,NFMAPS=1,IMG_W=4,IMG_H=4, pixels 1..16 back-to-back -> four valid pulses, windows {1,2,5,6},{3,4,7,8},{9,10,13,14},{11,12,15,16} (element 0 at LSB), first valid one cycle after pixel 6; frame_done with last window.
REQ-032 Same stream with in_valid toggled 1,0,1,0 -> identical windows, each valid one cycle after its BR pixel.
REQ-033 IMG_W=5,IMG_H=5, pixels 1..25 -> exactly 4 windows: {1,2,6,7},{3,4,8,9},{11,12,16,17},{13,14,18,19}; frame_done after pixel 25 with valid=0.
REQ-034 Reset asserted after pixel 7 of 4x4 frame, then pixels 1..16 -> only the four windows of REQ-031, none from pre-reset data.
REQ-035 in_sof on pixel 3 of a frame, then 16 pixels 101..116 -> windows {101,102,105,106} onward.
REQ-036 NFMAPS=2, fmap1 = fmap0+0x80 -> fmap1 slice equals fmap0 slice +0x80 per element, in the upper 32 bits.
